program_stream_loader: RTL and testbench
========================================

PROGRAM_STREAM_LOADER -- requirements
Module: program_stream_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0000: RAM word address of first loaded instruction.
REQ-002 SHALL have parameter MAX_WORDS, default 256: largest accepted program length in words.
REQ-003 SHALL have port clock, input, 1: sole clock; all state changes on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: single-cycle load request, sampled only in IDLE, DONE or ERROR.
REQ-006 SHALL have port rx_valid, input, 1: byte available on rx_data.
REQ-007 SHALL have port rx_data, input, 8: program byte stream.
REQ-008 SHALL have port rx_ready, output, 1: byte accepted when rx_valid and rx_ready are high on the same posedge.
REQ-009 SHALL have port mem_write, output, 1: one-cycle RAM write strobe.
REQ-010 SHALL have port mem_addr, output, 16: RAM word address.
REQ-011 SHALL have port mem_write_data, output, 16: instruction word.
REQ-012 SHALL have port busy, output, 1: load in progress.
REQ-013 SHALL have port done, output, 1: level; program loaded and CPU may execute.
REQ-014 SHALL have port error, output, 1: level; load aborted.

Function
REQ-015 SHALL implement the states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE and ERROR.
REQ-016 SHALL expect a stream of length high byte, length low byte, then N words sent high byte first.
REQ-017 SHALL move to LEN_HI on start and clear done, error and the word counter.
REQ-018 SHALL drive rx_ready high only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
REQ-019 SHALL enter ERROR without writing if, after LEN_LO, N > MAX_WORDS.
REQ-020 SHALL go directly to CHECK if N == 0.
REQ-021 SHALL, on the cycle after the DATA_LO byte is accepted (WRITE), assert mem_write for exactly 1 cycle with mem_addr = BASE_ADDR + index and mem_write_data = {hi, lo}.
REQ-022 SHALL keep rx_ready low in WRITE.
REQ-023 SHALL compute mem_addr modulo 2^16, so that addresses wrap past 16'hFFFF.
REQ-024 SHALL, after the Nth write, go to CHECK; otherwise it SHALL return to DATA_HI.
REQ-025 SHALL never write the same address twice within one load.
REQ-026 SHALL assert busy in every state except IDLE, DONE and ERROR.
REQ-027 SHALL hold done or error until the next accepted start or reset.
REQ-028 SHALL ignore start while busy.
REQ-029 SHALL wait indefinitely with no timeout when rx_valid is low.

Reset
REQ-030 SHALL, on reset, force state to IDLE and clear rx_ready, mem_write, mem_addr, mem_write_data, busy, done, error and all counters to 0.
REQ-031 SHALL, when reset is asserted mid-load, abort the load with no further writes; words already written SHALL remain in RAM.
REQ-032 SHALL give reset priority over start when both are high in the same cycle.

Configuration
REQ-033 SHALL, with LOADER_CHECKSUM_EN defined, accept one trailing byte in CHECK and compare it to the XOR of all preceding bytes, including the length bytes; a match SHALL go to DONE and a mismatch SHALL go to ERROR.
REQ-034 SHALL, without LOADER_CHECKSUM_EN, pass CHECK in 1 cycle to DONE, consume no byte, and keep rx_ready low in CHECK.

Structure
REQ-035 SHALL place the state enum, the LEN/DATA byte-order constants and the default MAX_WORDS in shared package loader_pkg.
REQ-036 SHALL use one sub-module, loader_xor_accum (8-bit running XOR, clear/enable), instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-037 SHALL cover: reset, start, bytes 00 02 12 34 AB CD with rx_valid held high -> writes 0000=1234 and 0001=ABCD, done=1 two cycles after the last write, error=0.
REQ-038 SHALL cover: bytes 00 00 -> no mem_write and done=1.
REQ-039 SHALL cover: bytes 01 01 with MAX_WORDS=256 -> error=1, no writes, and rx_ready low afterwards.
REQ-040 SHALL cover: BASE_ADDR=16'hFFFF, 2 words -> writes at FFFF then 0000.
REQ-041 SHALL cover: reset after the first of 3 words -> state IDLE, busy=0, no further mem_write; a subsequent start and a full stream -> done=1.
REQ-042 SHALL cover, with LOADER_CHECKSUM_EN: stream 00 01 12 34 followed by checksum 27 -> done=1; the same stream followed by 00 -> error=1, and the word is still written.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program stream loader.
//   loader_state_t    : loader FSM states
//   LEN_MSB_FIRST     : length field arrives high byte first
//   DATA_MSB_FIRST    : each instruction word arrives high byte first
//   MAX_WORDS_DEFAULT : default upper bound on program length (words)
//   join_bytes()      : assembles a 16-bit field from two stream bytes
package loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam bit LEN_MSB_FIRST     = 1'b1;
  localparam bit DATA_MSB_FIRST    = 1'b1;
  localparam int MAX_WORDS_DEFAULT = 256;

  // first/second are in stream arrival order
  function automatic logic [15:0] join_bytes(input logic [7:0] first,
                                             input logic [7:0] second,
                                             input bit         msb_first);
    return msb_first ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/program_stream_loader_if.sv
// Byte-stream input and RAM write port of the program stream loader.
//   rx_valid/rx_data/rx_ready : byte stream handshake (byte taken when valid & ready)
//   mem_write                 : one-cycle RAM write strobe
//   mem_addr/mem_write_data   : RAM word address and instruction word
// Modports: slave = loader side, master = stream source / RAM side.
interface program_stream_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_write_data;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_write, mem_addr, mem_write_data
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_write, mem_addr, mem_write_data
  );
endinterface

// File: rtl/loader_xor_accum.sv
// 8-bit running XOR accumulator used for the optional stream checksum.
//   clock, reset : clock and synchronous active-high reset
//   i_clear      : zero the accumulator (wins over i_enable)
//   i_enable     : fold i_data into the accumulator
//   i_data       : byte to accumulate
//   o_acc        : current XOR of all bytes since the last clear
module loader_xor_accum (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [7:0] i_data,
  output logic [7:0] o_acc
);

  logic [7:0] r_acc;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/program_stream_loader.sv
// Program stream loader: receives a byte stream of the form
//   LEN_HI LEN_LO {W_HI W_LO} x N [CHECKSUM]
// and writes the N words to RAM at BASE_ADDR, BASE_ADDR+1, ... (mod 2^16).
// Optional feature macro LOADER_CHECKSUM_EN: one trailing byte is taken in
// CHECK and must equal the XOR of all preceding bytes, length included.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   start               : load request, honoured only in IDLE/DONE/ERROR
//   bus (slave)         : rx_valid/rx_data/rx_ready stream, mem_* RAM write
//   busy                : load in progress
//   done / error        : level, held until next accepted start or reset
// Parameters: BASE_ADDR (first RAM word address), MAX_WORDS (length limit).
module program_stream_loader
  import loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  program_stream_loader_if.slave         bus,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);

  loader_state_t r_state;
  logic [7:0]    r_first;      // first byte of the current length/data pair
  logic [15:0]   r_len;
  logic [16:0]   r_idx;        // one extra bit so N up to 65535 terminates cleanly
  logic          r_mem_write;
  logic [15:0]   r_mem_addr;
  logic [15:0]   r_mem_wdata;

  logic          w_rx_ready;
  logic          w_accept;
  logic          w_idle_like;
  logic [15:0]   w_len_next;
  logic [16:0]   w_idx_inc;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CHECK_TAKES_BYTE = 1'b1;
`else
  localparam bit CHECK_TAKES_BYTE = 1'b0;
`endif

  assign w_idle_like = (r_state == IDLE) || (r_state == DONE) || (r_state == ERROR);
  assign w_rx_ready  = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                       (r_state == DATA_HI) || (r_state == DATA_LO) ||
                       (CHECK_TAKES_BYTE && (r_state == CHECK));
  assign w_accept    = bus.rx_valid && w_rx_ready;
  assign w_len_next  = join_bytes(r_first, bus.rx_data, LEN_MSB_FIRST);
  assign w_idx_inc   = r_idx + 17'd1;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] w_csum;
  logic       w_csum_clr;
  logic       w_csum_en;

  // Every byte before the checksum itself feeds the running XOR.
  assign w_csum_clr = w_idle_like && start;
  assign w_csum_en  = w_accept && (r_state != CHECK);

  loader_xor_accum u_csum (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_csum_clr),
    .i_enable (w_csum_en),
    .i_data   (bus.rx_data),
    .o_acc    (w_csum)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_first     <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_write <= 1'b0;
      unique case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_state <= LEN_HI;
            r_idx   <= '0;
          end
        end
        LEN_HI: begin
          if (w_accept) begin
            r_first <= bus.rx_data;
            r_state <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len_next;
            if (w_len_next == 16'd0) begin
              r_state <= CHECK;
            end else if (int'(w_len_next) > MAX_WORDS) begin
              r_state <= ERROR;
            end else begin
              r_state <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (w_accept) begin
            r_first <= bus.rx_data;
            r_state <= DATA_LO;
          end
        end
        DATA_LO: begin
          // Address and data are registered here so the strobe in WRITE
          // comes straight from flops; the 16-bit add wraps past FFFF.
          if (w_accept) begin
            r_mem_addr  <= BASE_ADDR + r_idx[15:0];
            r_mem_wdata <= join_bytes(r_first, bus.rx_data, DATA_MSB_FIRST);
            r_mem_write <= 1'b1;
            r_state     <= WRITE;
          end
        end
        WRITE: begin
          r_idx <= w_idx_inc;
          if (w_idx_inc == {1'b0, r_len}) begin
            r_state <= CHECK;
          end else begin
            r_state <= DATA_HI;
          end
        end
        CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (w_accept) begin
            r_state <= (bus.rx_data == w_csum) ? DONE : ERROR;
          end
`else
          r_state <= DONE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rx_ready       = w_rx_ready;
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_write_data = r_mem_wdata;

  assign busy  = !w_idle_like;
  assign done  = (r_state == DONE);
  assign error = (r_state == ERROR);

endmodule

// File: tb/tb_program_stream_loader.sv
// Testbench for program_stream_loader. Two instances share one stimulus
// stream: dut0 with BASE_ADDR 0000, dut1 with BASE_ADDR FFFF (address wrap).
// Works with and without LOADER_CHECKSUM_EN defined.
module tb_program_stream_loader;
  import loader_pkg::*;

  localparam int MAXW = 256;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       busy0, done0, error0, busy1, done1, error1;

  program_stream_loader_if bus0 ();
  program_stream_loader_if bus1 ();

  assign bus0.rx_valid = rx_valid;
  assign bus0.rx_data  = rx_data;
  assign bus1.rx_valid = rx_valid;
  assign bus1.rx_data  = rx_data;

  program_stream_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(MAXW)) dut0 (
    .clock(clock), .reset(reset), .start(start), .bus(bus0),
    .busy(busy0), .done(done0), .error(error0)
  );

  program_stream_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(MAXW)) dut1 (
    .clock(clock), .reset(reset), .start(start), .bus(bus1),
    .busy(busy1), .done(done1), .error(error1)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_wr = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];

  always @(negedge clock) begin
    wr_t e;
    if (bus0.mem_write) begin
      last_wr = cyc;
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr0_unexpected: got write %h=%h, required no write", bus0.mem_addr, bus0.mem_write_data);
      end else begin
        e = q0.pop_front();
        chk("wr0_addr", 32'(bus0.mem_addr), 32'(e.addr));
        chk("wr0_data", 32'(bus0.mem_write_data), 32'(e.data));
      end
    end
    if (bus1.mem_write) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr1_unexpected: got write %h=%h, required no write", bus1.mem_addr, bus1.mem_write_data);
      end else begin
        e = q1.pop_front();
        chk("wr1_addr", 32'(bus1.mem_addr), 32'(e.addr));
        chk("wr1_data", 32'(bus1.mem_write_data), 32'(e.data));
      end
    end
  end

  // ---------------- reference model ----------------
  // From the raw byte list: how many bytes the loader consumes, the words it
  // must write (in order), and whether the load ends in error.
  bit          m_err;
  int          m_nbytes;
  logic [15:0] m_words[$];

  function automatic void model(input logic [7:0] s[$]);
    int         n;
    logic [7:0] x;
    m_words.delete();
    m_err = 1'b0;
    n = int'({s[0], s[1]});
    if (n > MAXW) begin
      m_err    = 1'b1;
      m_nbytes = 2;
      return;
    end
    for (int i = 0; i < n; i++) m_words.push_back({s[2 + 2 * i], s[3 + 2 * i]});
    m_nbytes = 2 + 2 * n;
    if (CSUM) begin
      x = 8'h00;
      for (int i = 0; i < m_nbytes; i++) x ^= s[i];
      m_err = (s[m_nbytes] != x);
      m_nbytes++;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  logic [7:0] st[$];

  function automatic void mk(input logic [63:0] v, input int n);
    st.delete();
    for (int i = 0; i < n; i++) st.push_back(v[8 * (n - 1 - i) +: 8]);
  endfunction

  // n words of random data, then a trailing checksum byte (optionally corrupted)
  function automatic void build_random(input int n, input bit bad);
    logic [7:0] x;
    st.delete();
    st.push_back(8'(n >> 8));
    st.push_back(8'(n));
    if (n <= MAXW)
      for (int i = 0; i < 2 * n; i++) st.push_back(8'($urandom));
    x = 8'h00;
    foreach (st[i]) x ^= st[i];
    if (bad) x ^= 8'($urandom_range(1, 255));
    st.push_back(x);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    if ($urandom_range(0, 7) == 0) start = 1'b1;  // loader is busy: must be ignored
    while (!bus0.rx_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!bus0.rx_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL rx_ready_timeout: got rx_ready=0 for byte %h, required 1", b);
    end else begin
      @(posedge clock);
    end
    #1;
    rx_valid = 1'b0;
    start    = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    chk("busy_after_start", 32'(busy0), 32'd1);
    chk("done_cleared", 32'(done0), 32'd0);
    chk("error_cleared", 32'(error0), 32'd0);
  endtask

  task automatic run_load(input logic [7:0] s[$], input bit gaps, input bit chk_lat);
    int w;
    model(s);
    foreach (m_words[i]) begin
      q0.push_back('{addr: 16'(i), data: m_words[i]});
      q1.push_back('{addr: 16'hFFFF + 16'(i), data: m_words[i]});
    end
    do_start();
    for (int i = 0; i < m_nbytes; i++) send_byte(s[i], gaps);
    w = 0;
    @(negedge clock);
    while (!(done0 || error0) && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("done", 32'(done0), 32'(!m_err));
    chk("error", 32'(error0), 32'(m_err));
    chk("busy_end", 32'(busy0), 32'd0);
    chk("done_dut1", 32'(done1), 32'(!m_err));
`ifndef LOADER_CHECKSUM_EN
    if (chk_lat) chk("done_latency", 32'(cyc - last_wr), 32'd2);
`endif
    repeat (3) @(negedge clock);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    if (m_err) chk("rx_ready_after_error", 32'(bus0.rx_ready), 32'd0);
    q0.delete();
    q1.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_error", 32'(error0), 32'd0);
    chk("rst_rx_ready", 32'(bus0.rx_ready), 32'd0);
    chk("rst_mem_write", 32'(bus0.mem_write), 32'd0);
    chk("rst_mem_addr", 32'(bus0.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus0.mem_write_data), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // two words, stream held valid, trailing correct checksum
    mk(64'h0000_0212_34AB_CD42, 7);
    run_load(st, 1'b0, 1'b1);
    // zero-length program
    mk(64'h0000_0000_0000_0000, 3);
    run_load(st, 1'b0, 1'b0);
    // length 257 > MAX_WORDS
    mk(64'h0000_0000_0000_0101, 2);
    run_load(st, 1'b0, 1'b0);
    // one word with correct / wrong checksum byte
    mk(64'h0000_0000_0112_3427, 5);
    run_load(st, 1'b0, 1'b0);
    mk(64'h0000_0000_0112_3400, 5);
    run_load(st, 1'b0, 1'b0);
    // length boundaries
    build_random(MAXW, 1'b0);
    run_load(st, 1'b0, 1'b0);
    build_random(MAXW + 1, 1'b0);
    run_load(st, 1'b0, 1'b0);

    // reset after the first of three words
    build_random(3, 1'b0);
    q0.push_back('{addr: 16'h0000, data: {st[2], st[3]}});
    q1.push_back('{addr: 16'hFFFF, data: {st[2], st[3]}});
    do_start();
    for (int i = 0; i < 4; i++) send_byte(st[i], 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    chk("midrst_error", 32'(error0), 32'd0);
    chk("midrst_rx_ready", 32'(bus0.rx_ready), 32'd0);
    chk("midrst_mem_write", 32'(bus0.mem_write), 32'd0);
    rx_valid = 1'b1;
    repeat (10) @(negedge clock) rx_data = 8'($urandom);
    rx_valid = 1'b0;
    chk("midrst_idle_busy", 32'(busy0), 32'd0);
    chk("midrst_q0_drained", 32'(q0.size()), 32'd0);
    build_random(3, 1'b0);
    run_load(st, 1'b0, 1'b0);

    // reset and start in the same cycle: reset wins
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    chk("rst_vs_start_busy", 32'(busy0), 32'd0);
    chk("rst_vs_start_done", 32'(done0), 32'd0);

    // randomized loads
    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = $urandom_range(MAXW + 1, 65535);
        default: n = $urandom_range(1, 8);
      endcase
      build_random(n, $urandom_range(0, 3) == 0);
      run_load(st, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
